// File: rtl/raster_pidx_fetch_if.sv
// Bundles the memory request/response and primitive-index output streams of raster_pidx_fetch.
// master = the fetch block, slave = the memory arbiter / setup stage side.
interface raster_pidx_fetch_if #(
   parameter int TAG_WIDTH = 4
);
   // Each channel moves one beat on a rising clk edge where valid && ready;
   // the sender holds valid and its payload stable until that beat.
   logic                 mem_req_valid;
   logic [31:0]          mem_req_addr;
   logic [TAG_WIDTH-1:0] mem_req_tag;
   logic                 mem_req_ready;
   logic                 mem_rsp_valid;
   logic [31:0]          mem_rsp_data;
   logic [TAG_WIDTH-1:0] mem_rsp_tag;
   logic                 mem_rsp_ready;
   logic                 pid_valid;
   logic [31:0]          pid_data;
   logic                 pid_last;
   logic                 pid_ready;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_tag,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      output mem_rsp_ready,
      output pid_valid, pid_data, pid_last,
      input  pid_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_tag,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
      input  mem_rsp_ready,
      input  pid_valid, pid_data, pid_last,
      output pid_ready
   );
endinterface

// File: rtl/raster_pidx_fetch.sv
// Streams pidx_size 32-bit primitive indices from pidx_addr (csrs[31:0], size in csrs[63:32]) to setup.
// Optional macro RASTER_PIDX_PERF_EN adds saturating memory/output stall counters.
module raster_pidx_fetch #(
   parameter int MAX_PENDING = 4,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [255:0]         csrs,
   raster_pidx_fetch_if.master  bus,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
`ifdef RASTER_PIDX_PERF_EN
   ,
   output logic [31:0]          perf_mem_stalls,
   output logic [31:0]          perf_out_stalls
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam int AW = $clog2(MAX_PENDING);

   logic [1:0]           state_q, state_d;
   logic [31:0]          base_q, base_d;
   logic [31:0]          size_q, size_d;
   logic [31:0]          req_cnt_q, req_cnt_d;
   logic [31:0]          out_cnt_q, out_cnt_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 done_q, done_d;
   logic [AW:0]          wr_ptr_q, rd_ptr_q;
   logic [31:0]          fifo_mem [MAX_PENDING];

   logic [31:0] pending;
   logic        req_fire, push, pop, fifo_empty;
   logic        unused_bits;

   // Pending covers issued-but-not-yet-output indices, so the FIFO can never be overrun.
   assign pending    = req_cnt_q - out_cnt_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);

   assign bus.mem_req_valid = (state_q == S_FETCH) && (req_cnt_q < size_q) &&
                              (pending < 32'(MAX_PENDING));
   assign bus.mem_req_addr  = base_q + {req_cnt_q[29:0], 2'b00};
   assign bus.mem_req_tag   = tag_q;
   assign bus.mem_rsp_ready = 1'b1;
   assign bus.pid_valid     = !fifo_empty;
   assign bus.pid_data      = fifo_mem[rd_ptr_q[AW-1:0]];
   assign bus.pid_last      = !fifo_empty && (out_cnt_q == size_q - 32'd1);

   assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
   assign push      = bus.mem_rsp_valid && (state_q != S_IDLE);
   assign pop       = !fifo_empty && bus.pid_ready;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;

   assign unused_bits = ^{csrs[255:64], bus.mem_rsp_tag};

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      size_d    = size_q;
      req_cnt_d = req_cnt_q + 32'(req_fire);
      out_cnt_d = out_cnt_q + 32'(pop);
      tag_d     = tag_q + TAG_WIDTH'(req_fire);
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (csrs[63:32] == 32'd0) begin
                  done_d = 1'b1;
               end else begin
                  base_d    = csrs[31:0];
                  size_d    = csrs[63:32];
                  req_cnt_d = 32'd0;
                  out_cnt_d = 32'd0;
                  state_d   = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (req_cnt_d == size_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_cnt_d == size_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         base_q    <= 32'd0;
         size_q    <= 32'd0;
         req_cnt_q <= 32'd0;
         out_cnt_q <= 32'd0;
         tag_q     <= '0;
         done_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         size_q    <= size_d;
         req_cnt_q <= req_cnt_d;
         out_cnt_q <= out_cnt_d;
         tag_q     <= tag_d;
         done_q    <= done_d;
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= bus.mem_rsp_data;
   end

`ifdef RASTER_PIDX_PERF_EN
   logic [31:0] perf_mem_q, perf_out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_mem_q <= 32'd0;
         perf_out_q <= 32'd0;
      end else begin
         if (bus.mem_req_valid && !bus.mem_req_ready && (perf_mem_q != '1))
            perf_mem_q <= perf_mem_q + 32'd1;
         if (bus.pid_valid && !bus.pid_ready && (perf_out_q != '1))
            perf_out_q <= perf_out_q + 32'd1;
      end
   end

   assign perf_mem_stalls = perf_mem_q;
   assign perf_out_stalls = perf_out_q;
`endif

endmodule

// File: tb/tb_raster_pidx_fetch.sv
// Randomized bench for raster_pidx_fetch: a queue-based model of the index stream and request
// sequence is checked every cycle, plus directed checks for reset, zero size, backpressure and wrap.
module tb_raster_pidx_fetch;
   localparam int MAXP = 4;
   localparam int TW   = 4;

   logic         clk = 1'b0;
   logic         reset, start, busy, done;
   logic [255:0] csrs;
   logic [1:0]   dbg_state;
`ifdef RASTER_PIDX_PERF_EN
   logic [31:0]  perf_mem_stalls, perf_out_stalls;
`endif

   raster_pidx_fetch_if #(.TAG_WIDTH(TW)) m ();

   raster_pidx_fetch #(.MAX_PENDING(MAXP), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset), .start(start), .csrs(csrs), .bus(m),
      .busy(busy), .done(done), .dbg_state(dbg_state)
`ifdef RASTER_PIDX_PERF_EN
      , .perf_mem_stalls(perf_mem_stalls), .perf_out_stalls(perf_out_stalls)
`endif
   );

   always #5 clk = ~clk;

   int unsigned     total, bad, dut_reqs;
   bit              active;
   logic [31:0]     base, size, issued, accepted, perf_mem_m, perf_out_m;
   logic [TW-1:0]   tag_cnt;
   logic [31:0]     rsp_q[$];
   logic [TW-1:0]   rsp_tag_q[$];
   logic [31:0]     exp_q[$];
   logic [31:0]     fixed_q[$];
   logic [31:0]     addr_log[$];
   logic [31:0]     tag_log[$];
   logic [31:0]     out_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_csrs();
      logic [255:0] c;
      for (int i = 0; i < 8; i++) c[i*32 +: 32] = $urandom();
      return c;
   endfunction

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_req_valid"}, m.mem_req_valid, 0);
      chk({pfx, "_req_addr"},  m.mem_req_addr, 0);
      chk({pfx, "_req_tag"},   m.mem_req_tag, 0);
      chk({pfx, "_pid_valid"}, m.pid_valid, 0);
      chk({pfx, "_pid_last"},  m.pid_last, 0);
      chk({pfx, "_busy"},      busy, 0);
      chk({pfx, "_done"},      done, 0);
   endtask

   task automatic clear_model();
      active = 0; tag_cnt = '0; issued = 0; accepted = 0;
      perf_mem_m = 0; perf_out_m = 0;
      rsp_q.delete(); rsp_tag_q.delete(); exp_q.delete();
   endtask

   // One clock of random handshakes; model state after the call reflects the coming edge.
   task automatic step(input int rq, input int pr, input int rs);
      bit rsp_fire, exp_rv, exp_pv;
      logic [31:0] d;
      @(negedge clk);
      m.mem_req_ready = ($urandom_range(99) < rq);
      m.pid_ready     = ($urandom_range(99) < pr);
      rsp_fire        = (rsp_q.size() != 0) && ($urandom_range(99) < rs);
      m.mem_rsp_valid = rsp_fire;
      m.mem_rsp_data  = rsp_fire ? rsp_q[0] : $urandom();
      m.mem_rsp_tag   = rsp_fire ? rsp_tag_q[0] : '0;
      start           = active && ($urandom_range(7) == 0);
      csrs            = rand_csrs();
      #1;
      exp_rv = active && (issued < size) && ((issued - accepted) < MAXP);
      exp_pv = (exp_q.size() != 0);
      chk("req_valid", m.mem_req_valid, exp_rv);
      if (exp_rv) begin
         chk("req_addr", m.mem_req_addr, base + (issued << 2));
         chk("req_tag",  m.mem_req_tag, tag_cnt);
      end
      chk("pid_valid", m.pid_valid, exp_pv);
      if (exp_pv) begin
         chk("pid_data", m.pid_data, exp_q[0]);
         chk("pid_last", m.pid_last, accepted == size - 32'd1);
      end else begin
         chk("pid_last_idle", m.pid_last, 0);
      end
      chk("busy", busy, active);
      chk("done_low", done, 0);
      if (m.mem_req_valid && m.mem_req_ready) dut_reqs++;
      if (exp_rv && !m.mem_req_ready) perf_mem_m++;
      if (exp_pv && !m.pid_ready) perf_out_m++;
      if (exp_pv && m.pid_ready) begin
         out_log.push_back(exp_q.pop_front());
         accepted++;
      end
      if (rsp_fire) begin
         exp_q.push_back(rsp_q.pop_front());
         void'(rsp_tag_q.pop_front());
      end
      if (exp_rv && m.mem_req_ready) begin
         addr_log.push_back(base + (issued << 2));
         tag_log.push_back(32'(tag_cnt));
         if (fixed_q.size() != 0) d = fixed_q.pop_front();
         else d = $urandom();
         rsp_q.push_back(d);
         rsp_tag_q.push_back(tag_cnt);
         issued++;
         tag_cnt++;
      end
   endtask

   task automatic do_start(input logic [31:0] b, input logic [31:0] s);
      logic [255:0] c;
      @(negedge clk);
      c = rand_csrs();
      c[31:0] = b;
      c[63:32] = s;
      csrs = c; start = 1'b1;
      m.mem_rsp_valid = 1'b0; m.mem_req_ready = 1'b0; m.pid_ready = 1'b0;
      #1;
      chk("start_busy", busy, 0);
      chk("start_done", done, 0);
      base = b; size = s; issued = 0; accepted = 0; active = (s != 0); dut_reqs = 0;
      addr_log.delete(); tag_log.delete(); out_log.delete();
   endtask

   task automatic finish_fetch(input int rq, input int pr, input int rs);
      int cyc;
      cyc = 0;
      while (accepted != size && cyc < 3000) begin
         step(rq, pr, rs);
         cyc++;
      end
      chk("fetch_complete", accepted, size);
      @(negedge clk);
      start = 1'b0; m.mem_rsp_valid = 1'b0;
      m.pid_ready = 1'($urandom_range(1)); m.mem_req_ready = 1'($urandom_range(1));
      #1;
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_req_valid", m.mem_req_valid, 0);
      chk("done_pid_valid", m.pid_valid, 0);
      active = 0;
      @(negedge clk);
      #1;
      chk("done_once", done, 0);
`ifdef RASTER_PIDX_PERF_EN
      chk("perf_mem", perf_mem_stalls, perf_mem_m);
      chk("perf_out", perf_out_stalls, perf_out_m);
`endif
   endtask

   initial begin
      int cyc;
      logic [31:0] exp_wrap [4];
      total = 0; bad = 0; dut_reqs = 0;
      clear_model();
      reset = 1'b1; start = 1'b0; csrs = '0;
      m.mem_req_ready = 1'b0; m.mem_rsp_valid = 1'b0; m.mem_rsp_data = '0;
      m.mem_rsp_tag = '0; m.pid_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_reset_vals("reset");
      reset = 1'b0;

      // Basic: three indices, no stalls
      fixed_q = '{32'd7, 32'd8, 32'd9};
      do_start(32'h1000, 3);
      finish_fetch(100, 100, 100);
      chk("basic_nreq", addr_log.size(), 3);
      chk("basic_nout", out_log.size(), 3);
      if (addr_log.size() == 3 && out_log.size() == 3) begin
         chk("basic_addr0", addr_log[0], 32'h1000);
         chk("basic_addr1", addr_log[1], 32'h1004);
         chk("basic_addr2", addr_log[2], 32'h1008);
         chk("basic_tag0", tag_log[0], 0);
         chk("basic_tag1", tag_log[1], 1);
         chk("basic_tag2", tag_log[2], 2);
         chk("basic_out0", out_log[0], 7);
         chk("basic_out1", out_log[1], 8);
         chk("basic_out2", out_log[2], 9);
      end

      // Zero size
      do_start(32'h2000, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_req_valid", m.mem_req_valid, 0);
      @(negedge clk);
      #1;
      chk("zero_done_once", done, 0);
      chk("zero_busy_after", busy, 0);

      // Backpressure: consumer stalled, at most MAXP requests outstanding
      do_start(32'h4000, 10);
      repeat (12) step(100, 0, 100);
      chk("bp_issued", dut_reqs, MAXP);
      chk("bp_req_low", m.mem_req_valid, 0);
      finish_fetch(100, 100, 100);
      chk("bp_total_reqs", dut_reqs, 10);

      // Address wrap
      exp_wrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      do_start(32'hFFFF_FFF8, 4);
      finish_fetch(70, 70, 70);
      chk("wrap_nreq", addr_log.size(), 4);
      if (addr_log.size() == 4)
         for (int i = 0; i < 4; i++) chk("wrap_addr", addr_log[i], exp_wrap[i]);

      // Memory stall with request held
      do_start(32'h5000, 6);
      step(100, 100, 100);
      for (int i = 0; i < 5; i++) begin
         step(0, 100, 100);
         chk("stall_addr", m.mem_req_addr, 32'h5004);
      end
      finish_fetch(100, 100, 100);

      // Random fetches
      for (int n = 0; n < 8; n++) begin
         do_start($urandom(), $urandom_range(1, 20));
         finish_fetch($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100));
      end

      // Reset mid-fetch
      do_start(32'h6000, 8);
      cyc = 0;
      while (issued < 2 && cyc < 50) begin
         step(100, 0, 0);
         cyc++;
      end
      chk("mid_issued", dut_reqs, 2);
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      #1 check_reset_vals("midrst");
      reset = 1'b0;
      clear_model();
      @(negedge clk);
      m.mem_rsp_valid = 1'b1; m.mem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      m.mem_rsp_valid = 1'b0;
      #1;
      chk("stale_dropped", m.pid_valid, 0);
      fixed_q = '{32'h55};
      do_start(32'h3000, 1);
      finish_fetch(100, 100, 100);
      chk("post_rst_nout", out_log.size(), 1);
      if (out_log.size() == 1) begin
         chk("post_rst_addr", addr_log[0], 32'h3000);
         chk("post_rst_tag", tag_log[0], 0);
         chk("post_rst_data", out_log[0], 32'h55);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
